// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised serial pattern detector:
// one-hot FSM encoding, legal parameter ranges and the fill-counter width helper.
package seq_det_pkg;

    localparam int unsigned PAT_W_MIN = 2;
    localparam int unsigned PAT_W_MAX = 16;
    localparam int unsigned CNT_W_MIN = 1;
    localparam int unsigned CNT_W_MAX = 32;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_UNLOADED = 3'b001;
    localparam state_t ST_FILL     = 3'b010;
    localparam state_t ST_DETECT   = 3'b100;

    // Fill counter must be able to hold the value PAT_W itself.
    function automatic int unsigned fill_width(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Stimulus/result bundle of the serial pattern detector; clk and rst stay outside.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 5,
    parameter int unsigned CNT_W = 8
);
    import seq_det_pkg::*;

    logic             in;
    logic             valid;
    logic [PAT_W-1:0] pattern;
    logic             load;
    logic             overlap;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             ready;

    modport master (
        output in, valid, pattern, load, overlap,
        input  out, match_cnt, ready
    );

    modport slave (
        input  in, valid, pattern, load, overlap,
        output out, match_cnt, ready
    );

endinterface

// File: rtl/seq_shift_hist.sv
// History shift register plus saturating fill counter; exposes the post-shift
// values so the caller can compare against them in the same cycle.
module seq_shift_hist
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W  = 5,
    parameter int unsigned FILL_W = fill_width(PAT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift,
    input  logic              restart,
    input  logic              in_bit,
    output logic [PAT_W-1:0]  hist_upd,
    output logic [FILL_W-1:0] fill_upd
);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q;
    logic [FILL_W-1:0] fill_q;

    always_comb begin
        hist_upd = hist_q;
        fill_upd = fill_q;
        if (shift) begin
            hist_upd = {hist_q[PAT_W-2:0], in_bit};
            if (fill_q != FILL_FULL) begin
                fill_upd = fill_q + 1'b1;
            end
        end
    end

    // restart drops only the fill count; stale history is masked by the count check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clear) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_upd;
            fill_q <= restart ? '0 : fill_upd;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, overlap control and a
// saturating match counter; out is a registered one-cycle pulse.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 5,
    parameter int unsigned CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst,
    seq_detector_param_if.slave bus
);

    localparam int unsigned       FILL_W    = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q;

    logic              shift;
    logic              match;
    logic              restart;
    logic [PAT_W-1:0]  hist_upd;
    logic [FILL_W-1:0] fill_upd;

    // load has priority over a coincident valid bit, which is dropped.
    assign shift   = bus.valid && !bus.load && (state_q != ST_UNLOADED);
    assign match   = shift && (hist_upd == pat_q) && (fill_upd == FILL_FULL);
    assign restart = match && !bus.overlap;

    seq_shift_hist #(
        .PAT_W  (PAT_W),
        .FILL_W (FILL_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.load),
        .shift    (shift),
        .restart  (restart),
        .in_bit   (bus.in),
        .hist_upd (hist_upd),
        .fill_upd (fill_upd)
    );

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ST_FILL;
        end else if (shift) begin
            if (restart) begin
                state_d = ST_FILL;
            end else if (fill_upd == FILL_FULL) begin
                state_d = ST_DETECT;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (bus.load) begin
            cnt_d = '0;
        end else if (match && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNLOADED;
            pat_q   <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= match;
            if (bus.load) begin
                pat_q <= bus.pattern;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;
    assign bus.ready     = (state_q != ST_UNLOADED);

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 5, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in  input  1  serial data bit, sampled only when valid=1.
REQ-006 SHALL have port valid  input  1  qualifies in for the current cycle.
REQ-007 SHALL have port pattern  input  PAT_W  target pattern; bit PAT_W-1 is the first-received bit; captured only on load.
REQ-008 SHALL have port load  input  1  captures pattern and restarts detection.
REQ-009 SHALL have port overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled on every valid cycle.
REQ-010 SHALL have port out  output  1  registered one-cycle match pulse.
REQ-011 SHALL have port match_cnt  output  CNT_W  saturating count of matches since reset or load.
REQ-012 SHALL have port ready  output  1  high once a pattern has been loaded.

Function
REQ-013 SHALL implement a three-state FSM: UNLOADED, FILL, DETECT.
REQ-014 In UNLOADED, SHALL ignore valid/in, hold out=0, and hold ready=0; load moves the FSM to FILL.
REQ-015 On load in any state, SHALL capture pattern, clear the history register and fill counter, clear match_cnt, set ready=1, and enter FILL.
REQ-016 On a valid cycle in FILL or DETECT, SHALL shift history left with in entering the LSB, and increment the fill counter, saturating at PAT_W.
REQ-017 FILL SHALL move to DETECT when the fill counter reaches PAT_W.
REQ-018 A match SHALL be declared when the updated history equals the captured pattern and the updated fill count equals PAT_W.
REQ-019 On a match, SHALL set out=1 for exactly one cycle, asserted on the edge that samples the final pattern bit, and drive out=0 in every other cycle.
REQ-020 On a match, SHALL increment match_cnt, holding at all-ones with no wrap.
REQ-021 On a match with overlap=1, SHALL keep history and fill count, so the next match may share bits.
REQ-022 On a match with overlap=0, SHALL clear the fill counter and enter FILL, so PAT_W fresh bits are needed.
REQ-023 On a cycle with valid=0, SHALL hold history, fill counter, state and match_cnt, and drive out=0.
REQ-024 When load and valid are both 1 in the same cycle, load SHALL win and the in bit SHALL be discarded.
REQ-025 When overlap changes value, SHALL apply the new value from the next valid cycle onward, with no retroactive effect.

Reset
REQ-026 On rst=1, SHALL immediately force out=0, match_cnt=0, ready=0, history=0, fill=0, captured pattern=0, and state=UNLOADED.
REQ-027 On rst=1 mid-stream, SHALL discard any partial match; detection resumes only after a new load.
REQ-028 Deassertion of rst SHALL take effect from the first following clk edge; no output glitches while rst=1.

Structure
REQ-029 SHALL place the FSM state encoding (one-hot, 3 bits) and the PAT_W/CNT_W range limits in shared package seq_det_pkg.
REQ-030 SHALL implement the history shift register plus fill counter as sub-module seq_shift_hist, parametrised by PAT_W; FSM, compare and counter stay in the top level.
REQ-031 SHALL contain no combinational path from in to out.

Verification
REQ-032 Bench SHALL cover: PAT_W=5, load 10010, overlap=1, valid=1, stream 1,0,0,1,0,0,1,0 -> out pulses after bit 5 and bit 8; match_cnt=2.
REQ-033 Bench SHALL cover: same stream with overlap=0 -> out pulses only after bit 5; match_cnt=1.
REQ-034 Bench SHALL cover: stream 1,0,0,1,0 with valid=0 gaps inserted between every bit -> single pulse on the valid cycle carrying the 5th bit; gaps produce out=0.
REQ-035 Bench SHALL cover: rst asserted after bits 1,0,0,1, then load 10010, then 0,1,0,0,1,0 -> exactly one pulse, on the last bit; no pulse from pre-reset bits.
REQ-036 Bench SHALL cover: CNT_W=2, overlap=1, pattern 11, PAT_W=2, stream of seven 1s -> six pulses, match_cnt saturates at 3.
REQ-037 Bench SHALL cover: load=1 and valid=1 in the same cycle with in=1 -> bit discarded; fill=0; ready=1; match_cnt=0.
